secure_memory_dump_reader: RTL

// - Initiator/reader for the badge challenge byte-memory interface: walks an address range,

---
 rtl/secure_memory_dump_reader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/secure_memory_dump_reader.sv
// Byte-memory walker: reads [start_addr..end_addr] (wrapping) from a 1-cycle synchronous
// memory and streams each byte with its address over a valid/ready handshake.
module secure_memory_dump_reader #(
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 8,
   parameter bit STOP_ON_ZERO = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_LATCH,
      S_HOLD,
      S_DONE
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

   state_t              r_state;
   state_t              w_next;
   logic                w_hs;
   logic                w_stop;
   logic [ADDR_W-1:0]   r_end;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_out_data;
   logic [ADDR_W-1:0]   r_out_addr;
   logic                r_out_valid;
   logic [ADDR_W:0]     r_count;

   assign w_stop    = STOP_ON_ZERO && (mem_data == '0);
   assign mem_addr  = r_mem_addr;
   assign out_data  = r_out_data;
   assign out_addr  = r_out_addr;
   assign out_valid = r_out_valid;
   assign count     = r_count;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      w_hs   = 1'b0;
      case (r_state)
         S_IDLE:  if (start && !abort) w_next = S_ISSUE;
         S_ISSUE: w_next = S_LATCH;
         S_LATCH: w_next = w_stop ? S_DONE : S_HOLD;
         S_HOLD: begin
            if (out_ready) begin
               w_hs   = 1'b1;
               w_next = (r_mem_addr == r_end) ? S_DONE : S_ISSUE;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
      // abort cancels an active walk and also swallows a same-cycle handshake
      if (abort && (r_state inside {S_ISSUE, S_LATCH, S_HOLD})) begin
         w_next = S_IDLE;
         w_hs   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_end       <= '0;
         r_mem_addr  <= '0;
         r_out_data  <= '0;
         r_out_addr  <= '0;
         r_out_valid <= 1'b0;
         r_count     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_next == S_ISSUE) begin
                  r_end      <= end_addr;
                  r_mem_addr <= start_addr;
                  r_count    <= '0;
               end
            end
            S_LATCH: begin
               if (w_next == S_HOLD) begin
                  r_out_data  <= mem_data;
                  r_out_addr  <= r_mem_addr;
                  r_out_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (w_next != S_HOLD) r_out_valid <= 1'b0;
               if (w_hs) begin
                  r_count <= r_count + CNT_ONE;
                  if (w_next == S_ISSUE) r_mem_addr <= r_mem_addr + ADDR_ONE;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
